// File: rtl/adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_pkg : nibble width, FSM state encoding and counter width helper    |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package adder_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A single-nibble add still needs a one-bit counter.
   function automatic int cnt_w(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_adder_if : operand/result valid-ready bundle               |
// | Optional overflow flag present when SERIAL_ADD_OVF_EN is defined.        |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   import adder_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             busy;
`ifdef SERIAL_ADD_OVF_EN
   logic             overflow;
`endif

   modport master (
      output in_valid, a, b, carry_in, out_ready,
`ifdef SERIAL_ADD_OVF_EN
      input  overflow,
`endif
      input  in_ready, out_valid, sum, carry_out, busy
   );

   modport slave (
      input  in_valid, a, b, carry_in, out_ready,
`ifdef SERIAL_ADD_OVF_EN
      output overflow,
`endif
      output in_ready, out_valid, sum, carry_out, busy
   );

endinterface
`default_nettype wire

// File: rtl/add4_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add4_cell : combinational 4-bit ripple-carry adder                       |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module add4_cell
   import adder_pkg::*;
(
   input  wire logic [NIB_W-1:0] a,
   input  wire logic [NIB_W-1:0] b,
   input  wire logic             ci,
   output      logic [NIB_W-1:0] s,
   output      logic             co
);

   logic [NIB_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIB_W; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_adder : WIDTH-bit add, one nibble per clock, valid/ready   |
// | Macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag.|
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input wire logic              clk,
   input wire logic              rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int CNT_W   = cnt_w(NIBBLES);

   if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               ovf_q, ovf_d;
`endif

   logic [NIB_W-1:0]       cell_s;
   logic                   cell_co;
   logic [WIDTH+NIB_W-1:0] sum_cat;
   logic                   last_nib;

   add4_cell u_cell (
      .a  (a_sr_q[NIB_W-1:0]),
      .b  (b_sr_q[NIB_W-1:0]),
      .ci (carry_q),
      .s  (cell_s),
      .co (cell_co)
   );

   // New nibble enters at the MSB end so the first nibble lands in bits [3:0].
   assign sum_cat  = {cell_s, sum_q};
   assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.carry_in;
               cnt_d   = '0;
               state_d = ST_RUN;
`ifdef SERIAL_ADD_OVF_EN
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
`endif
            end
         end
         ST_RUN: begin
            a_sr_d  = a_sr_q >> NIB_W;
            b_sr_d  = b_sr_q >> NIB_W;
            sum_d   = sum_cat[WIDTH+NIB_W-1:NIB_W];
            carry_d = cell_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_nib) begin
               state_d = ST_DONE;
               cout_d  = cell_co;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = (a_msb_q == b_msb_q) && (cell_s[NIB_W-1] != a_msb_q);
`endif
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.overflow  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_serial_adder : directed self-checking bench, WIDTH=16          |
// | Overflow vectors are exercised when SERIAL_ADD_OVF_EN is defined.        |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!bus.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
   endtask

   // Accept operands and wait for out_valid; returns edges from accept to valid.
   task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, output int lat);
      wait_ready();
      bus.a        = a;
      bus.b        = b;
      bus.carry_in = ci;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = 16'hDEAD;
      bus.b        = 16'hBEEF;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] exp_sum, input logic exp_co,
                          input logic exp_ovf);
      int lat;
      start_and_wait(a, b, ci, lat);
      check_eq({tag, "_latency"}, 32'(lat), 32'd4);
      check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
      check_eq({tag, "_carry_out"}, 32'(bus.carry_out), 32'(exp_co));
`ifdef SERIAL_ADD_OVF_EN
      check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) $display("unexpected x overflow expectation");
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.carry_in  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_sum", 32'(bus.sum), 32'd0);
      check_eq("rst_carry_out", 32'(bus.carry_out), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);

      run_add("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_add("t3a", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      run_add("t3b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      run_add("mix", 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);

      // Backpressure: result must hold while out_ready is low; in_valid ignored.
      start_and_wait(16'h0F0F, 16'h0101, 1'b0, lat);
      check_eq("bp_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'h1111;
         bus.b        = 16'h2222;
         @(negedge clk);
         check_eq("bp_sum", 32'(bus.sum), 32'h1010);
         check_eq("bp_carry_out", 32'(bus.carry_out), 32'd0);
         check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

      // Reset sampled at the second RUN edge discards the partial result.
      wait_ready();
      bus.a        = 16'h5678;
      bus.b        = 16'h1111;
      bus.carry_in = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("mid_rst_sum", 32'(bus.sum), 32'd0);
      check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      run_add("t5", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      run_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_add("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_add("ovf_none", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
